csr_trap_unit: RTL
==================

# csr_trap_unit

Machine-mode CSR file with trap and interrupt handling for the single-hart RV core, parametrised in XLEN and trap-vector mode. It sits beside the register file in EXU, executes all six Zicsr read-modify-write operations, owns mcycle/minstret, and takes exceptions, interrupts and mret. On a trap or mret it drives a same-cycle PC redirect to IFU.

## Interface
- XLEN, 64, data width; 32 or 64 only
- RESET_MTVEC, 0, mtvec reset value
- VECTORED_EN, 1, 1 honours mtvec.MODE=1; 0 forces direct mode
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- csr_valid  in  1  CSR instruction in this cycle
- csr_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csr_idx  in  12  CSR address
- src  in  XLEN  rs1 value, or zimm zero-extended for immediate forms
- src_is_x0  in  1  rs1/zimm field is zero (suppresses RS/RC writes)
- ecall, ebreak, mret  in  1 each  decoded system instruction, one-hot
- irq_ok  in  1  instruction boundary; interrupts may be taken
- inst_retire  in  1  an instruction completes this cycle
- pc  in  XLEN  PC of current instruction
- mtip, msip, meip  in  1 each  level interrupt lines
- rdata  out  XLEN  old CSR value (to rd)
- illegal  out  1  unimplemented CSR, or write to read-only CSR
- redirect  out  1  trap or mret taken this cycle
- redirect_pc  out  XLEN  next PC when redirect=1

## Operation
- Implemented: mstatus 300, misa 301 (RO), mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344 (RO), mcycle B00, minstret B02, mhartid F14 (RO, 0); mcycleh/minstreth B80/B82 only when XLEN=32.
- Write value: RW = src; RS = old|src; RC = old&~src. RS/RC with src_is_x0 perform no write and never flag illegal on RO CSRs.
- mstatus: only MIE[3], MPIE[7] writable; MPP[12:11] hardwired 11; others read reset value. mepc[1:0] read/write 0. mtvec[1] reads 0; MODE bit reads 0 when VECTORED_EN=0. mie writable bits 3,7,11 only.
- mip[3/7/11] mirror msip/mtip/meip; read-only.
- Pending = mip & mie & {MIE}. Taken only when irq_ok. Priority meip (11) > msip (3) > mtip (7).
- Trap priority: interrupt > illegal (cause 2) > ebreak (3) > ecall (11). Interrupt cause sets bit XLEN-1.
- Trap entry: mepc<=pc, mcause<=cause, mtval<=0, MPIE<=MIE, MIE<=0. redirect_pc = mtvec base; vectored interrupts: base+4*cause[XLEN-2:0].
- mret (no trap pending): MIE<=MPIE, MPIE<=1, redirect_pc=mepc.
- mcycle +1 every cycle; minstret +1 on inst_retire without trap. Both wrap to 0 at 2^XLEN (XLEN=32: 64-bit split across low/high).

## Timing
- rdata, illegal, redirect, redirect_pc combinational from current state and inputs; all state updates on rising clk.
- Same cycle trap and CSR write: write suppressed, trap state wins; rdata still returns old value.
- CSR write to mcycle/minstret beats the increment that cycle; next cycle counts from written value.
- Write to mepc/mstatus with same-cycle mret: mret uses pre-write values, write suppressed.
- Reset: mstatus = 0xa00001800 (XLEN=64) / 0x1800 (XLEN=32), mtvec = RESET_MTVEC, all others 0; outputs: redirect=0, illegal=0. Reset mid-trap discards the trap; no state update that cycle.

## Structure
- Package csr_pkg: CSR address constants, csr_op encodings, cause codes, mstatus bit positions, mstatus reset constants per XLEN.
- Sub-module csr_counter: 64-bit counter with inc and priority write-low/write-high ports; instantiated for mcycle and minstret.

## Test plan
- After reset, read 300 -> rdata 0xa00001800; read B00 next-next cycle -> 2; redirect=0.
- CSRRW 305 src 0x80000001, then CSRRS 304 src 0x80; mtip=1, MIE set via CSRRSI 300 zimm 8, irq_ok=1 -> redirect_pc 0x8000001C, mcause 0x8000000000000007, MIE=0, MPIE=1.
- ecall at pc 0x80000100 -> mepc 0x80000100, mcause 11, redirect_pc = mtvec base; mret -> redirect_pc 0x80000100, MIE restored.
- meip+msip+mtip together, all enabled -> cause 11 interrupt; ecall same cycle -> interrupt wins, mepc=pc.
- CSRRW F14 -> illegal=1, no write; CSRRS F14 with src_is_x0 -> illegal=0, rdata 0.
- CSRRW B02 0xFFFFFFFFFFFFFFFF, retire next cycle -> minstret 0 (wrap); CSRRW B00 with same-cycle increment -> written value held.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR/trap unit: addresses, op encodings,
// cause codes and mstatus layout.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [2:0] {
    OP_RW  = 3'b001,
    OP_RS  = 3'b010,
    OP_RC  = 3'b011,
    OP_RWI = 3'b101,
    OP_RSI = 3'b110,
    OP_RCI = 3'b111
  } csr_op_e;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] IRQ_MSI       = 4'd3;
  localparam logic [3:0] IRQ_MTI       = 4'd7;
  localparam logic [3:0] IRQ_MEI       = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // MPP=11 always; on RV64 SXL/UXL also read as 2 (64-bit).
  localparam logic [63:0] MSTATUS_RST64 = 64'h0000_000a_0000_1800;
  localparam logic [63:0] MSTATUS_RST32 = 64'h0000_0000_0000_1800;

endpackage

// File: rtl/csr_counter.sv
// 64-bit event counter; a write to either half takes priority over the
// increment in the same cycle.
module csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [63:0] wr_dat_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wr_dat_i[31:0];
      if (wr_hi_i) cnt_d[63:32] = wr_dat_i[63:32];
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with exception/interrupt entry and mret; redirect and
// read data are combinational, all state commits on the rising edge.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0,
  parameter bit              VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_idx,
  input  logic [XLEN-1:0] src,
  input  logic            src_is_x0,
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            mret,
  input  logic            irq_ok,
  input  logic            inst_retire,
  input  logic [XLEN-1:0] pc,
  input  logic            mtip,
  input  logic            msip,
  input  logic            meip,
  output logic [XLEN-1:0] rdata,
  output logic            illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [63:0]     MST64         = (XLEN == 64) ? MSTATUS_RST64 : MSTATUS_RST32;
  localparam logic [XLEN-1:0] MSTATUS_RST   = MST64[XLEN-1:0];
  localparam logic [XLEN-1:0] MIE_WMASK     = XLEN'(12'h888);
  localparam logic [XLEN-1:0] EPC_MASK      = ~XLEN'(3);
  localparam logic [XLEN-1:0] TVEC_MASK     = VECTORED_EN ? ~XLEN'(2) : ~XLEN'(3);

  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0]     mcycle_cnt, minstret_cnt, cnt_wdat;

  logic [XLEN-1:0] mstatus_rd, mip_v, mepc_rd, tvec_base, wval, trap_cause;
  logic            csr_known, csr_ro, wr_req, ill_raw, csr_we;
  logic            irq_take, trap, mret_take;
  logic [3:0]      irq_code;

  assign mstatus_rd = MSTATUS_RST | (XLEN'(mstatus_mpie_q) << MSTATUS_MPIE)
                                  | (XLEN'(mstatus_mie_q) << MSTATUS_MIE);
  assign mip_v      = XLEN'({meip, 3'b000, mtip, 3'b000, msip, 3'b000});
  assign mepc_rd    = mepc_q & EPC_MASK;
  assign tvec_base  = mtvec_q & ~XLEN'(3);

  always_comb begin
    rdata     = '0;
    csr_known = 1'b1;
    csr_ro    = 1'b0;
    case (csr_idx)
      CSR_MSTATUS:   rdata = mstatus_rd;
      CSR_MISA:      csr_ro = 1'b1;
      CSR_MIE:       rdata = mie_q;
      CSR_MTVEC:     rdata = mtvec_q & TVEC_MASK;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_rd;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MTVAL:     rdata = mtval_q;
      CSR_MIP:       begin rdata = mip_v; csr_ro = 1'b1; end
      CSR_MCYCLE:    rdata = mcycle_cnt[XLEN-1:0];
      CSR_MINSTRET:  rdata = minstret_cnt[XLEN-1:0];
      CSR_MCYCLEH:   if (XLEN == 32) rdata = XLEN'(mcycle_cnt[63:32]);   else csr_known = 1'b0;
      CSR_MINSTRETH: if (XLEN == 32) rdata = XLEN'(minstret_cnt[63:32]); else csr_known = 1'b0;
      CSR_MHARTID:   csr_ro = 1'b1;
      default:       csr_known = 1'b0;
    endcase
  end

  // Set/clear forms with rs1=x0 are pure reads, so they never count as writes.
  always_comb begin
    wr_req = 1'b0;
    wval   = src;
    case (csr_op)
      OP_RW, OP_RWI: begin wr_req = csr_valid;               wval = src;          end
      OP_RS, OP_RSI: begin wr_req = csr_valid && !src_is_x0; wval = rdata | src;  end
      OP_RC, OP_RCI: begin wr_req = csr_valid && !src_is_x0; wval = rdata & ~src; end
      default:       begin wr_req = 1'b0;                    wval = src;          end
    endcase
  end

  assign ill_raw = csr_valid && (!csr_known || (wr_req && csr_ro));

  always_comb begin
    irq_take = 1'b0;
    irq_code = 4'd0;
    if (irq_ok && mstatus_mie_q) begin
      if (meip && mie_q[11])     begin irq_take = 1'b1; irq_code = IRQ_MEI; end
      else if (msip && mie_q[3]) begin irq_take = 1'b1; irq_code = IRQ_MSI; end
      else if (mtip && mie_q[7]) begin irq_take = 1'b1; irq_code = IRQ_MTI; end
    end
  end

  assign trap      = irq_take || ill_raw || ebreak || ecall;
  assign mret_take = mret && !trap;

  always_comb begin
    if (irq_take)    trap_cause = (XLEN'(1) << (XLEN-1)) | XLEN'(irq_code);
    else if (ill_raw) trap_cause = XLEN'(CAUSE_ILLEGAL);
    else if (ebreak)  trap_cause = XLEN'(CAUSE_BREAK);
    else              trap_cause = XLEN'(CAUSE_ECALL_M);
  end

  always_comb begin
    if (!trap)                                        redirect_pc = mepc_rd;
    else if (irq_take && VECTORED_EN && mtvec_q[0])   redirect_pc = tvec_base + (XLEN'(irq_code) << 2);
    else                                              redirect_pc = tvec_base;
  end

  assign illegal  = !rst && ill_raw;
  assign redirect = !rst && (trap || mret_take);

  // mret consumes mstatus/mepc as they were, so a same-cycle write to them is dropped.
  assign csr_we = wr_req && !ill_raw && !trap &&
                  !(mret_take && (csr_idx == CSR_MSTATUS || csr_idx == CSR_MEPC));

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else if (trap) begin
      mepc_q         <= pc & EPC_MASK;
      mcause_q       <= trap_cause;
      mtval_q        <= '0;
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else begin
      if (mret_take) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
      if (csr_we) begin
        case (csr_idx)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= wval[MSTATUS_MIE];
            mstatus_mpie_q <= wval[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= wval & MIE_WMASK;
          CSR_MTVEC:    mtvec_q    <= wval;
          CSR_MSCRATCH: mscratch_q <= wval;
          CSR_MEPC:     mepc_q     <= wval & EPC_MASK;
          CSR_MCAUSE:   mcause_q   <= wval;
          CSR_MTVAL:    mtval_q    <= wval;
          default: ;
        endcase
      end
    end
  end

  assign cnt_wdat = (XLEN == 64) ? 64'(wval) : {2{wval[31:0]}};

  csr_counter u_mcycle (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (1'b1),
    .wr_lo_i  (csr_we && csr_idx == CSR_MCYCLE),
    .wr_hi_i  (csr_we && ((XLEN == 64) ? (csr_idx == CSR_MCYCLE) : (csr_idx == CSR_MCYCLEH))),
    .wr_dat_i (cnt_wdat),
    .cnt_o    (mcycle_cnt)
  );

  csr_counter u_minstret (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (inst_retire && !trap),
    .wr_lo_i  (csr_we && csr_idx == CSR_MINSTRET),
    .wr_hi_i  (csr_we && ((XLEN == 64) ? (csr_idx == CSR_MINSTRET) : (csr_idx == CSR_MINSTRETH))),
    .wr_dat_i (cnt_wdat),
    .cnt_o    (minstret_cnt)
  );

endmodule
